hazard_stall_unit: RTL and testbench

- Generates the stall signal `st` consumed by the ID-stage control decoder of the 5-stage pipeline.
- Also generates `pc_write` and `ifid_write`, which freeze the fetch and ID stages during a stall.
- Keeps an internal 3-deep scoreboard of in-flight destination registers (EX, MEM, WB slots).
- Compares the scoreboard against the source registers of the instruction in ID and holds it until the operands are available.

---
 rtl/hazard_stall_unit.sv | 122 ++++++++++++
 tb/tb_hazard_stall_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use / RAW stall generator for the 5-stage pipeline.
// Rev 1.0 - three-slot destination scoreboard (EX, MEM, WB) with saturating stall counter.
`default_nettype none

module hazard_stall_unit #(
  parameter int REG_W       = 3,
  parameter int FWD         = 1,
  parameter int ZERO_REG_HW = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [3:0]       id_opcode,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  output logic             st,
  output logic             pc_write,
  output logic             ifid_write,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [3:0] c_op_add   = 4'b0000;
  localparam logic [3:0] c_op_nandi = 4'b0001;
  localparam logic [3:0] c_op_sub   = 4'b0011;
  localparam logic [3:0] c_op_lw    = 4'b0111;
  localparam logic [3:0] c_op_nor   = 4'b1111;

  // Slot 0 = EX, 1 = MEM, 2 = WB.
  logic             r_v    [3];
  logic [REG_W-1:0] r_dest [3];
  logic             r_ld   [3];
  logic [CNT_W-1:0] r_cnt;

  logic             w_reads_rs;
  logic             w_reads_rt;
  logic             w_writes;
  logic             w_is_lw;
  logic [REG_W-1:0] w_dest;
  logic             w_rs_ok;
  logic             w_rt_ok;
  logic [2:0]       w_hit;
  logic [2:0]       w_policy;

  always_comb begin
    w_reads_rs = 1'b0;
    w_reads_rt = 1'b0;
    w_writes   = 1'b0;
    w_is_lw    = 1'b0;
    w_dest     = id_rd;
    case (id_opcode)
      c_op_add, c_op_sub, c_op_nor: begin
        w_reads_rs = 1'b1;
        w_reads_rt = 1'b1;
        w_writes   = 1'b1;
        w_dest     = id_rd;
      end
      c_op_nandi: begin
        w_reads_rs = 1'b1;
        w_writes   = 1'b1;
        w_dest     = id_rt;
      end
      c_op_lw: begin
        w_reads_rs = 1'b1;
        w_writes   = 1'b1;
        w_is_lw    = 1'b1;
        w_dest     = id_rt;
      end
      default: begin
        w_reads_rs = 1'b0;
      end
    endcase
  end

  assign w_rs_ok = w_reads_rs & ((ZERO_REG_HW == 0) || (id_rs != '0));
  assign w_rt_ok = w_reads_rt & ((ZERO_REG_HW == 0) || (id_rt != '0));

  // Which slots are allowed to stall: with forwarding only a load in EX,
  // without it anything in EX or MEM. WB never stalls (write-before-read file).
  assign w_policy[0] = (FWD != 0) ? r_ld[0] : 1'b1;
  assign w_policy[1] = (FWD == 0);
  assign w_policy[2] = 1'b0;

  generate
    for (genvar i = 0; i < 3; i++) begin : g_slot
      assign w_hit[i] = r_v[i] & ((w_rs_ok & (id_rs == r_dest[i])) |
                                  (w_rt_ok & (id_rt == r_dest[i])));
    end
  endgenerate

  assign st         = id_valid & |(w_hit & w_policy);
  assign pc_write   = ~st;
  assign ifid_write = ~st;
  assign stall_cnt  = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        r_v[i]    <= 1'b0;
        r_dest[i] <= '0;
        r_ld[i]   <= 1'b0;
      end
      r_cnt <= '0;
    end else begin
      r_v[0]    <= id_valid & ~st & w_writes;
      r_dest[0] <= w_dest;
      r_ld[0]   <= id_valid & ~st & w_writes & w_is_lw;
      for (int i = 1; i < 3; i++) begin
        r_v[i]    <= r_v[i-1];
        r_dest[i] <= r_dest[i-1];
        r_ld[i]   <= r_ld[i-1];
      end
      if (st && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: two instances (forwarding / no forwarding with 4-bit counter)
// driven by directed and random instruction streams against an issue-history model.
`default_nettype none

module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] valid;
  logic [3:0] op [2];
  logic [2:0] rs [2];
  logic [2:0] rt [2];
  logic [2:0] rd [2];
  logic [1:0] st;
  logic [1:0] pcw;
  logic [1:0] ifw;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  always #5 clk = ~clk;

  hazard_stall_unit #(.REG_W(3), .FWD(1), .ZERO_REG_HW(1), .CNT_W(16)) u_fwd (
    .clk(clk), .rst_n(rst_n), .id_valid(valid[0]), .id_opcode(op[0]),
    .id_rs(rs[0]), .id_rt(rt[0]), .id_rd(rd[0]),
    .st(st[0]), .pc_write(pcw[0]), .ifid_write(ifw[0]), .stall_cnt(cnt0)
  );

  hazard_stall_unit #(.REG_W(3), .FWD(0), .ZERO_REG_HW(1), .CNT_W(4)) u_nofwd (
    .clk(clk), .rst_n(rst_n), .id_valid(valid[1]), .id_opcode(op[1]),
    .id_rs(rs[1]), .id_rt(rt[1]), .id_rd(rd[1]),
    .st(st[1]), .pc_write(pcw[1]), .ifid_write(ifw[1]), .stall_cnt(cnt1)
  );

  typedef struct packed {
    logic       v;
    logic [3:0] op;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [2:0] rd;
  } instr_t;

  typedef struct packed {
    logic       v;
    logic [2:0] d;
    logic       ld;
  } slot_t;

  instr_t q0 [$];
  instr_t q1 [$];
  instr_t cur [2];
  slot_t  hist [2][2];  // [instance][age-1]: what issued 1 and 2 cycles ago
  int     mcnt [2];
  int     cmax [2];
  bit     exp_st [2];
  bit     rand_mode;
  int     checks;
  int     failures;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic bit is_rrr(input logic [3:0] o);
    return (o == 4'd0) || (o == 4'd3) || (o == 4'd15);
  endfunction

  function automatic bit is_rwi(input logic [3:0] o);
    return (o == 4'd1) || (o == 4'd7);
  endfunction

  function automatic bit depends(input instr_t i, input logic [2:0] d);
    bit rs_used = is_rrr(i.op) || is_rwi(i.op);
    bit rt_used = is_rrr(i.op);
    return (rs_used && i.rs != 3'd0 && i.rs == d) || (rt_used && i.rt != 3'd0 && i.rt == d);
  endfunction

  // Forwarding: only a load issued on the previous cycle blocks.
  // No forwarding: any writer issued one or two cycles ago blocks.
  function automatic bit model_stall(input int k);
    int depth = (k == 0) ? 1 : 2;
    if (!cur[k].v) return 1'b0;
    for (int a = 0; a < depth; a++) begin
      if (hist[k][a].v && (k == 1 || hist[k][a].ld) && depends(cur[k], hist[k][a].d))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic instr_t mk(input logic [3:0] o, input logic [2:0] s, input logic [2:0] t,
                                input logic [2:0] d);
    instr_t i;
    i.v = 1'b1; i.op = o; i.rs = s; i.rt = t; i.rd = d;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    logic [3:0] ops [6];
    ops[0] = 4'd0; ops[1] = 4'd3; ops[2] = 4'd15; ops[3] = 4'd1; ops[4] = 4'd7;
    ops[5] = 4'($urandom_range(0, 15));
    i.v  = ($urandom_range(0, 4) != 0);
    i.op = ops[$urandom_range(0, 5)];
    i.rs = 3'($urandom_range(0, 7));
    i.rt = 3'($urandom_range(0, 7));
    i.rd = 3'($urandom_range(0, 7));
    return i;
  endfunction

  function automatic instr_t next_instr(input int k);
    instr_t i = '0;
    if (k == 0 && q0.size() > 0) i = q0.pop_front();
    else if (k == 1 && q1.size() > 0) i = q1.pop_front();
    else if (rand_mode) i = rand_instr();
    return i;
  endfunction

  task automatic drive(input int k);
    valid[k] = cur[k].v;
    op[k]    = cur[k].op;
    rs[k]    = cur[k].rs;
    rt[k]    = cur[k].rt;
    rd[k]    = cur[k].rd;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      hist[k][0] = '0;
      hist[k][1] = '0;
      mcnt[k]    = 0;
      exp_st[k]  = 1'b0;
      cur[k]     = '0;
      drive(k);
    end
  endtask

  task automatic drive_check();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!exp_st[k]) cur[k] = next_instr(k);
      drive(k);
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_st[k] = model_stall(k);
      chk($sformatf("st%0d", k), 32'(st[k]), 32'(exp_st[k]));
      chk($sformatf("pc_write%0d", k), 32'(pcw[k]), 32'(!exp_st[k]));
      chk($sformatf("ifid_write%0d", k), 32'(ifw[k]), 32'(!exp_st[k]));
      chk($sformatf("stall_cnt%0d", k), (k == 0) ? 32'(cnt0) : 32'(cnt1), 32'(mcnt[k]));
    end
  endtask

  task automatic commit();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      slot_t s = '0;
      bit wr = is_rrr(cur[k].op) || is_rwi(cur[k].op);
      if (cur[k].v && !exp_st[k] && wr) begin
        s.v  = 1'b1;
        s.d  = is_rrr(cur[k].op) ? cur[k].rd : cur[k].rt;
        s.ld = (cur[k].op == 4'd7);
      end
      hist[k][1] = hist[k][0];
      hist[k][0] = s;
      if (exp_st[k] && mcnt[k] < cmax[k]) mcnt[k]++;
    end
  endtask

  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      drive_check();
      commit();
    end
  endtask

  initial begin
    bit reached;
    checks = 0; failures = 0; rand_mode = 1'b0;
    cmax[0] = 65535; cmax[1] = 15;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_st%0d", k), 32'(st[k]), 32'd0);
      chk($sformatf("rst_pcw%0d", k), 32'(pcw[k]), 32'd1);
      chk($sformatf("rst_ifw%0d", k), 32'(ifw[k]), 32'd1);
    end
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Forwarding instance: load-use, forwarded ALU dep, r0 and undefined-opcode cases.
    q0.push_back(mk(4'd7, 3'd1, 3'd2, 3'd0));
    q0.push_back(mk(4'd0, 3'd2, 3'd3, 3'd4));
    q0.push_back(mk(4'd0, 3'd1, 3'd1, 3'd5));
    q0.push_back(mk(4'd3, 3'd5, 3'd1, 3'd6));
    q0.push_back(mk(4'd7, 3'd1, 3'd0, 3'd0));
    q0.push_back(mk(4'd0, 3'd0, 3'd1, 3'd4));
    q0.push_back(mk(4'd7, 3'd1, 3'd2, 3'd0));
    q0.push_back(mk(4'd5, 3'd2, 3'd2, 3'd2));
    // No-forwarding instance: EX dependency (2 cycles) then MEM dependency (1 cycle).
    q1.push_back(mk(4'd3, 3'd1, 3'd2, 3'd3));
    q1.push_back(mk(4'd15, 3'd3, 3'd1, 3'd7));
    q1.push_back(mk(4'd3, 3'd1, 3'd2, 3'd3));
    q1.push_back(mk(4'd0, 3'd1, 3'd1, 3'd6));
    q1.push_back(mk(4'd15, 3'd3, 3'd1, 3'd7));
    step(16);
    chk("dir_cnt_fwd", 32'(cnt0), 32'd1);
    chk("dir_cnt_nofwd", 32'(cnt1), 32'd3);

    // Asynchronous reset in the middle of a stall.
    q1.push_back(mk(4'd3, 3'd1, 3'd2, 3'd3));
    q1.push_back(mk(4'd15, 3'd3, 3'd1, 3'd7));
    reached = 1'b0;
    for (int c = 0; c < 8 && !reached; c++) begin
      drive_check();
      if (exp_st[1]) reached = 1'b1;
      else commit();
    end
    chk("async_stall_seen", 32'(st[1]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_st", 32'(st[1]), 32'd0);
    chk("async_pcw", 32'(pcw[1]), 32'd1);
    chk("async_cnt", 32'(cnt1), 32'd0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;

    rand_mode = 1'b1;
    step(400);
    chk("sat_cnt_nofwd", 32'(cnt1), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
